// File: rtl/CURVE_PARAMS.sv
// rtl/CURVE_PARAMS.sv - field constants, QPMM operand type and exponentiation FSM states
package CURVE_PARAMS;

  localparam int FP_W     = 27;
  localparam int LAT_QPMM = 3;

  typedef logic [FP_W-1:0] qpmm_fp_t;

  localparam logic [63:0] Mod     = 64'd65521;
  localparam logic [63:0] M_tilde = Mod;
  localparam logic [63:0] INV_EXP = Mod - 64'd2;

  function automatic logic [63:0] pow_mod(input logic [63:0] b, input logic [63:0] e,
                                          input logic [63:0] m);
    logic [63:0] r;
    logic [63:0] x;
    r = 64'd1;
    x = b % m;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r;
  endfunction

  // -Mod^-1 mod 2^FP_W by Newton iteration; an odd Mod is its own inverse mod 8
  function automatic qpmm_fp_t neg_inv(input logic [63:0] m);
    logic [63:0] inv;
    logic [63:0] n;
    inv = m;
    for (int i = 0; i < 5; i++) inv = inv * (64'd2 - m * inv);
    n = 64'd0 - inv;
    return n[FP_W-1:0];
  endfunction

  localparam logic [63:0] R_MOD    = (64'd1 << FP_W) % Mod;
  localparam qpmm_fp_t    ONE_MONT = R_MOD[FP_W-1:0];
  localparam logic [63:0] R_INV    = pow_mod(R_MOD, Mod - 64'd2, Mod);
  localparam qpmm_fp_t    M_PRIME  = neg_inv(Mod);

  typedef enum logic [2:0] {
    IDLE,
    SQ_ISS,
    SQ_WAIT,
    MU_ISS,
    MU_WAIT,
    FIN
  } exp_state_t;

endpackage

// File: rtl/QPMM_d0.sv
// rtl/QPMM_d0.sv - pipelined Montgomery multiplier, Z = A*B/R mod Mod in redundant form
module QPMM_d0
  import CURVE_PARAMS::*;
#(
  parameter int LAT = LAT_QPMM
) (
  input  logic     clk,
  input  logic     rstn,
  input  qpmm_fp_t A,
  input  qpmm_fp_t B,
  output qpmm_fp_t Z
);

  localparam int PW = 2 * FP_W;

  logic [PW-1:0] t;
  logic [PW-1:0] u;
  qpmm_fp_t      m;
  qpmm_fp_t      z_c;
  qpmm_fp_t      pipe [LAT];

  // R = 2^FP_W exceeds 1024^2*Mod/1023, so inputs below 1024*M_tilde map back into that range
  always_comb begin
    t   = PW'(A) * PW'(B);
    m   = t[FP_W-1:0] * M_PRIME;
    u   = t + PW'(m) * PW'(Mod);
    z_c = qpmm_fp_t'(u >> FP_W);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= z_c;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign Z = pipe[LAT-1];

endmodule

// File: rtl/qpmm_exp.sv
// rtl/qpmm_exp.sv - left-to-right square-and-multiply exponentiation over one QPMM_d0
module qpmm_exp
  import CURVE_PARAMS::*;
#(
  parameter int EXP_W = 384,
  parameter int LAT   = LAT_QPMM
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  qpmm_fp_t         base,
  input  logic [EXP_W-1:0] exp,
  output logic             busy,
  output logic             done,
  output qpmm_fp_t         result
);

  localparam int IDX_W  = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam int WCNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  exp_state_t        state;
  qpmm_fp_t          acc;
  qpmm_fp_t          b_r;
  logic [EXP_W-1:0]  e_r;
  logic [IDX_W-1:0]  idx;
  logic [WCNT_W-1:0] wcnt;
  qpmm_fp_t          op_a;
  qpmm_fp_t          op_b;
  qpmm_fp_t          z;

  assign op_a = acc;
  assign op_b = (state == MU_ISS) ? b_r : acc;

  QPMM_d0 #(.LAT(LAT)) u_qpmm (
    .clk  (clk),
    .rstn (rstn),
    .A    (op_a),
    .B    (op_b),
    .Z    (z)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      acc    <= '0;
      b_r    <= '0;
      e_r    <= '0;
      idx    <= '0;
      wcnt   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          // the done cycle still shows busy, so a start there is dropped
          done <= 1'b0;
          if (start && !busy) begin
            acc   <= ONE_MONT;
            b_r   <= base;
            e_r   <= exp;
            idx   <= IDX_W'(EXP_W - 1);
            busy  <= 1'b1;
            state <= SQ_ISS;
          end else begin
            busy <= 1'b0;
          end
        end
        SQ_ISS: begin
          wcnt  <= '0;
          state <= SQ_WAIT;
        end
        MU_ISS: begin
          wcnt  <= '0;
          state <= MU_WAIT;
        end
        SQ_WAIT, MU_WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == WCNT_W'(LAT - 1)) begin
            acc <= z;
            if (state == SQ_WAIT && e_r[idx]) begin
              state <= MU_ISS;
            end else if (idx == '0) begin
              state <= FIN;
            end else begin
              idx   <= idx - 1'b1;
              state <= SQ_ISS;
            end
          end
        end
        FIN: begin
          done   <= 1'b1;
          result <= acc;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
